piso_tx: RTL and testbench

- Parallel-in serial-out transmitter. Accepts an N-bit word through a ready/load handshake and shifts it out one bit per enabled clock, MSB first by default.
- Frames the serial bits with a valid strobe and pulses done when the word has finished.
- It is the transmit end of the serial link whose receive end deserialises back into the parallel register stage.

---
 rtl/piso_tx_pkg.sv | 14 +
 rtl/d_ffN.sv | 21 ++
 rtl/piso_tx.sv | 91 +++++++++
 tb/tb_piso_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the piso_tx serial transmitter.
package piso_tx_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-counter width for an n-bit word, never narrower than one bit.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/d_ffN.sv
// N-bit D register with load enable and asynchronous active-low reset.
module d_ffN #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         n_res,
  input  logic         en,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  // Capture d_i whenever en is high; otherwise hold.
  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      q_o <= '0;
    end else if (en) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: ready/load capture, one bit per enabled
// clock, framed by sframe and closed by a one-cycle done pulse.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         n_res,
  input  logic         en,
  input  logic [N-1:0] D,
  input  logic         load,
  output logic         ready,
  output logic         sout,
  output logic         sframe,
  output logic         done
);

  localparam int CNT_W = calc_cnt_w(N);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sout_q;
  logic               sframe_q;
  logic               done_q;
  logic [N-1:0]       word_q;
  logic               last_s;
  logic               cap_s;
  logic               head_s;
  logic [CNT_W-1:0]   nxt_idx_s;

  assign last_s = (state_q == SHIFT) && (cnt_q == '0);
  assign ready  = (state_q == IDLE) || last_s;
  assign cap_s  = en && load && ready;

  // The captured word stays still; cnt_q selects which bit goes out next.
  d_ffN #(.N(N)) u_hold (
    .clk   (clk),
    .n_res (n_res),
    .en    (cap_s),
    .d_i   (D),
    .q_o   (word_q)
  );

  // First bit comes straight from D; later bits are picked out of word_q.
  always_comb begin
    head_s    = 1'b0;
    nxt_idx_s = '0;
    if (LSB_FIRST) begin
      head_s    = D[0];
      nxt_idx_s = CNT_W'(N) - cnt_q;
    end else begin
      head_s    = D[N-1];
      nxt_idx_s = cnt_q - CNT_W'(1);
    end
  end

  // Transmit FSM with registered serial outputs.
  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (!en) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_s;
      if (cap_s) begin
        state_q  <= SHIFT;
        cnt_q    <= CNT_W'(N - 1);
        sout_q   <= head_s;
        sframe_q <= 1'b1;
      end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
        cnt_q  <= cnt_q - CNT_W'(1);
        sout_q <= word_q[nxt_idx_s];
      end else if (state_q == SHIFT) begin
        state_q  <= IDLE;
        sout_q   <= 1'b0;
        sframe_q <= 1'b0;
      end
    end
  end

  assign sout   = sout_q;
  assign sframe = sframe_q;
  assign done   = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx (N=8): MSB-first and LSB-first instances
// driven in parallel and compared against a word/position reference model.
`timescale 1ps/1ps
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       n_res;
  logic       en;
  logic       load;
  logic [7:0] D;
  logic       ready, sout, sframe, done;
  logic       ready_l, sout_l, sframe_l, done_l;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: current word, bits still to show, position in order.
  logic [7:0] m_w    = 8'h00;
  int         m_rem  = 0;
  int         m_pos  = 0;
  logic       m_done = 1'b0;

  typedef struct {
    logic       e;
    logic       l;
    logic [7:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[10];

  piso_tx #(.N(8), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .n_res(n_res), .en(en), .D(D), .load(load),
    .ready(ready), .sout(sout), .sframe(sframe), .done(done)
  );

  piso_tx #(.N(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .n_res(n_res), .en(en), .D(D), .load(load),
    .ready(ready_l), .sout(sout_l), .sframe(sframe_l), .done(done_l)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {sout, sframe, done, ready}.
  function automatic logic [3:0] model_exp(input bit lsb);
    logic b;
    b = 1'b0;
    if (m_rem > 0) b = lsb ? m_w[m_pos] : m_w[7-m_pos];
    return {b, (m_rem > 0), m_done, (m_rem <= 1)};
  endfunction

  task automatic model_edge();
    if (!en) begin
      m_done = 1'b0;
    end else begin
      m_done = (m_rem == 1);
      if (load && (m_rem <= 1)) begin
        m_w   = D;
        m_pos = 0;
        m_rem = 8;
      end else if (m_rem > 0) begin
        m_pos++;
        m_rem--;
      end
    end
  endtask

  task automatic model_reset();
    m_rem  = 0;
    m_pos  = 0;
    m_done = 1'b0;
  endtask

  task automatic step(input logic e, input logic l, input logic [7:0] d);
    en   = e;
    load = l;
    D    = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("msb_outs", 32'({sout, sframe, done, ready}), 32'(model_exp(1'b0)));
    check("lsb_outs", 32'({sout_l, sframe_l, done_l, ready_l}), 32'(model_exp(1'b1)));
  endtask

  initial begin
    logic [15:0] got;
    logic [16:0] dmask;
    int          nfr;
    logic [7:0]  aa;

    n_res = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    D     = 8'h00;
    #5;
    check("reset_outs", 32'({sout, sframe, done, ready}), 32'(4'b0001));
    check("reset_outs_l", 32'({sout_l, sframe_l, done_l, ready_l}), 32'(4'b0001));
    #5 n_res = 1'b1;
    @(negedge clk);
    model_reset();

    // Single word 0xAA, table-driven with literal expectations.
    aa = 8'hAA;
    tbl[0] = '{e: 1'b1, l: 1'b1, d: 8'hAA, exp: 4'b1100};
    for (int i = 1; i < 7; i++) tbl[i] = '{e: 1'b1, l: 1'b0, d: 8'h00, exp: {aa[7-i], 3'b100}};
    tbl[7] = '{e: 1'b1, l: 1'b0, d: 8'h00, exp: 4'b0101};
    tbl[8] = '{e: 1'b1, l: 1'b0, d: 8'h00, exp: 4'b0011};
    tbl[9] = '{e: 1'b1, l: 1'b0, d: 8'h00, exp: 4'b0001};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].e, tbl[i].l, tbl[i].d);
      check($sformatf("tbl_row%0d", i), 32'({sout, sframe, done, ready}), 32'(tbl[i].exp));
    end

    // Back-to-back A5 then 3C, load held until the second capture.
    got = '0; dmask = '0; nfr = 0;
    for (int s = 0; s < 17; s++) begin
      step(1'b1, (s <= 8), (s < 8) ? 8'hA5 : 8'h3C);
      if (s < 16) begin
        got[15-s] = sout;
        if (sframe) nfr++;
      end
      dmask[s] = done;
    end
    check("b2b_bits", 32'(got), 32'(16'hA53C));
    check("b2b_frames", 32'(nfr), 32'(16));
    check("b2b_done", 32'(dmask), 32'(17'h10100));
    check("b2b_idle", 32'(sframe), 32'(1'b0));

    // Enable stall after three bits of F0; load during stall is ignored.
    got = '0; dmask = '0; nfr = 0;
    for (int s = 0; s < 13; s++) begin
      if (s >= 3 && s <= 6) step(1'b0, 1'b1, 8'h0F);
      else step(1'b1, (s == 0), 8'hF0);
      if (s < 12) begin
        got[11-s] = sout;
        if (sframe) nfr++;
      end
      dmask[s] = done;
    end
    check("stall_bits", 32'(got[11:0]), 32'(12'hFF0));
    check("stall_frames", 32'(nfr), 32'(12));
    check("stall_done", 32'(dmask[12:0]), 32'(13'h1000));

    // Busy load of 0x55 during bit 3 of 0xAA.
    got = '0;
    for (int s = 0; s < 9; s++) begin
      step(1'b1, (s == 0) || (s == 3), (s == 0) ? 8'hAA : 8'h55);
      if (s < 8) got[7-s] = sout;
    end
    check("busy_bits", 32'(got[7:0]), 32'(8'hAA));
    check("busy_end", 32'({sframe, done}), 32'(2'b01));

    // Reset during bit 5 of C3, then a fresh word 81.
    step(1'b1, 1'b1, 8'hC3);
    for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 8'h00);
    #10 n_res = 1'b0;
    #5;
    check("midrst_outs", 32'({sout, sframe, done, ready}), 32'(4'b0001));
    check("midrst_outs_l", 32'({sout_l, sframe_l, done_l, ready_l}), 32'(4'b0001));
    model_reset();
    #5 n_res = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    check("midrst_nodone", 32'({sframe, done}), 32'(2'b00));
    got = '0;
    for (int s = 0; s < 9; s++) begin
      step(1'b1, (s == 0), 8'h81);
      if (s < 8) got[7-s] = sout;
    end
    check("midrst_next", 32'(got[7:0]), 32'(8'h81));

    // LSB-first instance with D=01.
    got = '0;
    for (int s = 0; s < 9; s++) begin
      step(1'b1, (s == 0), 8'h01);
      if (s < 8) got[7-s] = sout_l;
    end
    check("lsb_bits", 32'(got[7:0]), 32'(8'h80));

    // Randomised traffic against the model.
    for (int s = 0; s < 400; s++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
